// File: rtl/ip_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ip_fifo_pkg
//   Shared types and helpers for the ip_sync_fifo codebase slice.
//
//   fifo_mode_e  : read-side behaviour of the FIFO
//                    MODE_STD  - registered dout, one cycle after rd_en
//                    MODE_FWFT - first-word-fall-through, dout shows the head
//   count_width(): width of an occupancy counter able to hold 0..(1<<depth)
// ----------------------------------------------------------------------------
package ip_fifo_pkg;

    typedef enum logic [0:0] {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy runs from 0 to 2**depth inclusive, so one extra bit is needed.
    function automatic int unsigned count_width(input int unsigned depth);
        return depth + 1;
    endfunction

    // Map the integer FWFT parameter onto the mode enum.
    function automatic fifo_mode_e mode_from_param(input int unsigned fwft);
        return (fwft != 0) ? MODE_FWFT : MODE_STD;
    endfunction

endpackage

// File: rtl/ip_fifo_ram.sv
// ----------------------------------------------------------------------------
// ip_fifo_ram
//   Storage array for ip_sync_fifo: (1<<DEPTH) entries of WIDTH bits with one
//   synchronous write port and one asynchronous (combinational) read port.
//   Contents are never reset; the FIFO control logic decides what is valid.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  log2 of the entry count
//
// Ports
//   clk    clock, writes happen on the rising edge
//   we     write enable
//   waddr  write address (DEPTH bits)
//   wdata  write data (WIDTH bits)
//   raddr  read address (DEPTH bits)
//   rdata  read data, combinational from mem[raddr]
// ----------------------------------------------------------------------------
module ip_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned N = 1 << DEPTH;

    logic [WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ip_sync_fifo.sv
// ----------------------------------------------------------------------------
// ip_sync_fifo
//   Single-clock FIFO with N = 1<<DEPTH entries, all of which are usable.
//   Occupancy is tracked with an explicit counter; full/empty and the
//   almost_* thresholds are decoded combinationally from that counter.
//
// Build option
//   IP_SYNC_FIFO_ERR_EN  when defined, builds sticky overflow/underflow flags
//                        (set on wr_en while full / rd_en while empty, cleared
//                        only by rst). When undefined, both ports are tied 0.
//
// Parameters
//   WIDTH     data word width in bits
//   DEPTH     log2 of the entry count
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//   FWFT      0: standard read (dout registered, 1-cycle latency)
//             1: first-word-fall-through (dout = head entry while !empty)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   wr_en, din    write request and data
//   full          count == N
//   almost_full   count >= AF_LEVEL
//   rd_en         read request (standard) / pop (FWFT)
//   dout          read data
//   empty         count == 0
//   almost_empty  count <= AE_LEVEL
//   count         occupancy, 0..N (DEPTH+1 bits)
//   overflow      sticky write-while-full flag
//   underflow     sticky read-while-empty flag
// ----------------------------------------------------------------------------
module ip_sync_fifo
    import ip_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = (1 << DEPTH) - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned N    = 1 << DEPTH;
    localparam int unsigned CW   = count_width(DEPTH);
    localparam fifo_mode_e  MODE = mode_from_param(FWFT);

    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_N   = CW'(N);

    // Elaboration-time sanity check on the thresholds.
    if (AF_LEVEL > N) begin : g_af_check
        $error("AF_LEVEL must not exceed the FIFO capacity");
    end
    if (AE_LEVEL > N) begin : g_ae_check
        $error("AE_LEVEL must not exceed the FIFO capacity");
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;

    // Acceptance is decided from the current flags only, so a write into an
    // empty FIFO never bypasses to the read side in the same cycle, and a
    // read from a full FIFO cannot make room for a same-cycle write.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Status flags (combinational from count)
    // ------------------------------------------------------------------------
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_N);
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign almost_empty = (32'(count_q) <= AE_LEVEL);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // A write presented together with rst must not land in the array.
    ip_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !rst),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    if (MODE == MODE_FWFT) begin : g_fwft
        // Head entry is visible directly; value is meaningless while empty.
        assign dout = rd_data;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= rd_data;
            end
        end

        assign dout = dout_q;
    end

    // ------------------------------------------------------------------------
    // Error flags
    // ------------------------------------------------------------------------
`ifdef IP_SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ip_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_ip_sync_fifo
//   Two instances (standard read and FWFT) share one stimulus stream and are
//   compared against a queue-based reference model of the FIFO.
// ----------------------------------------------------------------------------
module tb_ip_sync_fifo;

    localparam int N = 4;
`ifdef IP_SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
    logic [7:0] s_dout;
    logic [2:0] s_count;
    logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
    logic [7:0] f_dout;
    logic [2:0] f_count;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_udf  = 1'b0;

    always #5 clk = ~clk;

    ip_sync_fifo #(
        .WIDTH(8), .DEPTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full),
        .almost_full(s_afull), .rd_en(rd_en), .dout(s_dout), .empty(s_empty),
        .almost_empty(s_aempty), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    ip_sync_fifo #(
        .WIDTH(8), .DEPTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full),
        .almost_full(f_afull), .rd_en(rd_en), .dout(f_dout), .empty(f_empty),
        .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply one cycle of stimulus, advance the model, return #1 after the edge.
    task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit rs);
        bit was_full;
        bit was_empty;
        wr_en = w;
        din   = d;
        rd_en = r;
        rst   = rs;
        was_full  = (mq.size() == N);
        was_empty = (mq.size() == 0);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full)  mq.push_back(d);
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 8'h00, 0, 1);
        tick(0, 8'h00, 0, 1);
        checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", s_count); end
        checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", s_empty); end
        checks++; if (s_aempty !== 1'b1) begin fails++; $display("FAIL reset_aempty: got %b expected 1", s_aempty); end
        checks++; if (s_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", s_full); end
        checks++; if (s_afull !== 1'b0) begin fails++; $display("FAIL reset_afull: got %b expected 0", s_afull); end
        checks++; if (s_dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", s_dout); end
        checks++; if ({s_ovf, s_udf} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b%b expected 00", s_ovf, s_udf); end
        checks++; if (f_empty !== 1'b1) begin fails++; $display("FAIL reset_fwft_empty: got %b expected 1", f_empty); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = 8'h11 * 8'(i + 1);
            tick(1, exp, 0, 0);
            checks++; if (s_count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_count, i + 1); end
            checks++; if (s_full !== (i == 3)) begin fails++; $display("FAIL fill_full[%0d]: got %b expected %b", i, s_full, i == 3); end
            checks++; if (s_afull !== (i >= 2)) begin fails++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, s_afull, i >= 2); end
            checks++; if (s_aempty !== (i == 0)) begin fails++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, s_aempty, i == 0); end
        end
        tick(1, 8'h55, 0, 0);
        checks++; if (s_count !== 3'd4) begin fails++; $display("FAIL fifth_write_count: got %0d expected 4", s_count); end
        checks++; if (s_ovf !== ERR_EN) begin fails++; $display("FAIL fifth_write_ovf: got %b expected %b", s_ovf, ERR_EN); end
        checks++; if (s_dout !== 8'h00) begin fails++; $display("FAIL pre_read_dout: got %h expected 00", s_dout); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h11 * 8'(i + 1);
            tick(0, 8'h00, 1, 0);
            checks++; if (s_dout !== exp) begin fails++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, s_dout, exp); end
            checks++; if (s_count !== 3'(3 - i)) begin fails++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, s_count, 3 - i); end
        end
        checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b expected 1", s_empty); end
    endtask

    task automatic test_wrap();
        bit w_pat [10] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 0};
        bit r_pat [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1};
        int c_pat [10] = '{1, 2, 3, 2, 2, 2, 1, 2, 1, 0};
        int wi = 0;
        int ri = 0;
        logic [7:0] exp;
        for (int k = 0; k < 10; k++) begin
            tick(w_pat[k], 8'h61 + 8'(wi), r_pat[k], 0);
            if (w_pat[k]) wi++;
            checks++; if (s_count !== 3'(c_pat[k])) begin fails++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, s_count, c_pat[k]); end
            if (r_pat[k]) begin
                exp = 8'h61 + 8'(ri);
                ri++;
                checks++; if (s_dout !== exp) begin fails++; $display("FAIL wrap_dout[%0d]: got %h expected %h", k, s_dout, exp); end
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(0, 8'h00, 0, 1);
        tick(1, 8'hC1, 0, 0);
        tick(1, 8'hC2, 0, 0);
        tick(1, 8'hC3, 1, 0);
        checks++; if (s_count !== 3'd2) begin fails++; $display("FAIL simul_mid_count: got %0d expected 2", s_count); end
        checks++; if (s_dout !== 8'hC1) begin fails++; $display("FAIL simul_mid_dout: got %h expected c1", s_dout); end
        tick(0, 8'h00, 0, 1);
        tick(1, 8'hD1, 1, 0);
        checks++; if (s_count !== 3'd1) begin fails++; $display("FAIL simul_empty_count: got %0d expected 1", s_count); end
        checks++; if (s_dout !== 8'h00) begin fails++; $display("FAIL simul_empty_dout: got %h expected 00", s_dout); end
        checks++; if (f_dout !== 8'hD1) begin fails++; $display("FAIL simul_empty_fwft: got %h expected d1", f_dout); end
        tick(1, 8'hD2, 0, 0);
        tick(1, 8'hD3, 0, 0);
        tick(1, 8'hD4, 0, 0);
        tick(1, 8'hEE, 1, 0);
        checks++; if (s_count !== 3'd3) begin fails++; $display("FAIL simul_full_count: got %0d expected 3", s_count); end
        checks++; if (s_dout !== 8'hD1) begin fails++; $display("FAIL simul_full_dout: got %h expected d1", s_dout); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 8'h00, 1, 0);
            checks++; if (s_dout !== 8'hD2 + 8'(i)) begin fails++; $display("FAIL simul_lost_dout[%0d]: got %h expected %h", i, s_dout, 8'hD2 + 8'(i)); end
        end
        checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL simul_lost_empty: got %b expected 1", s_empty); end
    endtask

    task automatic test_fwft();
        tick(0, 8'h00, 0, 1);
        tick(1, 8'hA5, 0, 0);
        checks++; if (f_empty !== 1'b0) begin fails++; $display("FAIL fwft_empty_after_wr: got %b expected 0", f_empty); end
        checks++; if (f_dout !== 8'hA5) begin fails++; $display("FAIL fwft_dout: got %h expected a5", f_dout); end
        tick(0, 8'h00, 1, 0);
        checks++; if (f_empty !== 1'b1) begin fails++; $display("FAIL fwft_empty_after_rd: got %b expected 1", f_empty); end
    endtask

    task automatic test_errors();
        tick(0, 8'h00, 0, 1);
        tick(0, 8'h00, 1, 0);
        checks++; if (s_udf !== ERR_EN) begin fails++; $display("FAIL err_udf_set: got %b expected %b", s_udf, ERR_EN); end
        tick(1, 8'h01, 0, 0);
        checks++; if (s_udf !== ERR_EN) begin fails++; $display("FAIL err_udf_sticky: got %b expected %b", s_udf, ERR_EN); end
        checks++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL err_ovf_early: got %b expected 0", s_ovf); end
        for (int i = 0; i < 4; i++) tick(1, 8'h02 + 8'(i), 0, 0);
        checks++; if (s_ovf !== ERR_EN) begin fails++; $display("FAIL err_ovf_set: got %b expected %b", s_ovf, ERR_EN); end
        checks++; if (f_ovf !== ERR_EN) begin fails++; $display("FAIL err_fwft_ovf: got %b expected %b", f_ovf, ERR_EN); end
        tick(0, 8'h00, 0, 1);
        checks++; if ({s_ovf, s_udf} !== 2'b00) begin fails++; $display("FAIL err_clear: got %b%b expected 00", s_ovf, s_udf); end
    endtask

    task automatic test_reset_mid();
        tick(0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, 8'h31 + 8'(i), 0, 0);
        checks++; if (s_count !== 3'd3) begin fails++; $display("FAIL rstmid_pre_count: got %0d expected 3", s_count); end
        tick(1, 8'h77, 0, 1);
        checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL rstmid_count: got %0d expected 0", s_count); end
        checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL rstmid_empty: got %b expected 1", s_empty); end
        tick(0, 8'h00, 0, 0);
        checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL rstmid_write_ignored: got %0d expected 0", s_count); end
    endtask

    task automatic test_random();
        bit w, r, rs;
        for (int k = 0; k < 400; k++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 99) < 2);
            tick(w, 8'($urandom), r, rs);
            checks++; if (s_count !== 3'(mq.size())) begin fails++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, s_count, mq.size()); end
            checks++; if ({s_full, s_afull, s_empty, s_aempty} !== {mq.size() == N, mq.size() >= 3, mq.size() == 0, mq.size() <= 1}) begin
                fails++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b for count %0d", k, s_full, s_afull, s_empty, s_aempty, mq.size());
            end
            checks++; if (s_dout !== m_dout) begin fails++; $display("FAIL rnd_dout[%0d]: got %h expected %h", k, s_dout, m_dout); end
            checks++; if ({s_ovf, s_udf} !== {ERR_EN && m_ovf, ERR_EN && m_udf}) begin
                fails++; $display("FAIL rnd_err[%0d]: got %b%b expected %b%b", k, s_ovf, s_udf, ERR_EN && m_ovf, ERR_EN && m_udf);
            end
            checks++; if (f_count !== 3'(mq.size())) begin fails++; $display("FAIL rnd_fwft_count[%0d]: got %0d expected %0d", k, f_count, mq.size()); end
            if (mq.size() != 0) begin
                checks++; if (f_dout !== mq[0]) begin fails++; $display("FAIL rnd_fwft_dout[%0d]: got %h expected %h", k, f_dout, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
